// File: rtl/pulse_width_detector.sv
// Pulse width detector: measures an asynchronous active-high pulse in whole
// milliseconds, classifies it against [MIN_MS, MAX_MS] and issues one report
// strobe per pulse. All state advances on the falling clock edge.
module pulse_width_detector #(
  parameter int CLK_FREQ    = 7159000,
  parameter int MIN_MS      = 10,
  parameter int MAX_MS      = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        _clk,
  input  logic        _reset,
  input  logic        pulse_in,
  output logic        busy,
  output logic        valid,
  output logic [15:0] width_ms,
  output logic        in_window,
  output logic        too_short,
  output logic        too_long
);

  localparam int TICKS = CLK_FREQ / 1000;
  localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int FW    = $clog2(SYNC_STAGES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(SYNC_STAGES);
  localparam logic [15:0]   MIN_W      = 16'(MIN_MS);
  localparam logic [15:0]   MAX_W      = 16'(MAX_MS);
  localparam logic [15:0]   TIMEOUT_W  = 16'(MAX_MS + 1);

  typedef enum logic [1:0] {
    ARM      = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 s_in, s_prev, rise, fall;
  logic [PW-1:0]        presc, presc_nxt;
  logic [15:0]          ms, ms_nxt;
  logic [FW-1:0]        fill, fill_nxt;
  logic                 wrap;
  logic                 report;
  logic [15:0]          report_w;

  assign s_in = sync[SYNC_STAGES-1];
  assign rise = s_in & ~s_prev;
  assign fall = ~s_in & s_prev;
  assign wrap = (presc == PRESC_LAST);
  assign busy = (state == MEASURE);

  // Synchroniser chain and one-cycle delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(negedge _clk or negedge _reset) begin
    if (!_reset) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pulse_in};
      s_prev <= s_in;
    end
  end

  // State, prescaler, ms counter and flush counter registers.
  always_ff @(negedge _clk or negedge _reset) begin
    if (!_reset) begin
      state <= ARM;
      presc <= '0;
      ms    <= '0;
      fill  <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      ms    <= ms_nxt;
      fill  <= fill_nxt;
    end
  end

  // Next-state and measurement logic. ARM first lets the cleared synchroniser
  // fill with real samples, so a pulse already high at reset release is seen
  // as high and skipped rather than mistaken for a fresh rise. Every MEASURE
  // cycle, including the fall cycle, advances the count, so a pulse of N
  // synchronised high cycles ends with ms*TICKS+presc == N.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    ms_nxt    = ms;
    fill_nxt  = fill;
    report    = 1'b0;
    report_w  = ms;
    unique case (state)
      ARM: begin
        if (fill != FILL_LAST) fill_nxt = fill + 1'b1;
        else if (!s_in)        state_nxt = IDLE;
      end
      IDLE: begin
        if (rise) begin
          presc_nxt = '0;
          ms_nxt    = '0;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (wrap && (ms == MAX_W)) begin
          // The count is about to pass MAX_MS: report now instead of waiting.
          report    = 1'b1;
          report_w  = TIMEOUT_W;
          state_nxt = fall ? IDLE : WAIT_LOW;
        end else begin
          presc_nxt = wrap ? '0 : presc + 1'b1;
          ms_nxt    = wrap ? ms + 1'b1 : ms;
          if (fall) begin
            report    = 1'b1;
            report_w  = ms_nxt;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_LOW: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = ARM;
    endcase
  end

  // Report registers: width and flags change only alongside the valid strobe.
  always_ff @(negedge _clk or negedge _reset) begin
    if (!_reset) begin
      valid     <= 1'b0;
      width_ms  <= '0;
      in_window <= 1'b0;
      too_short <= 1'b0;
      too_long  <= 1'b0;
    end else begin
      valid <= report;
      if (report) begin
        width_ms  <= report_w;
        in_window <= (report_w >= MIN_W) && (report_w <= MAX_W);
        too_short <= (report_w < MIN_W);
        too_long  <= (report_w > MAX_W);
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_detector.sv
// Directed bench for pulse_width_detector with TICKS=10, MIN_MS=2, MAX_MS=5.
// Inputs change and outputs are sampled on the rising edge, away from the
// falling edge on which the design updates.
module tb_pulse_width_detector;

  logic        _clk = 1'b0;
  logic        _reset = 1'b0;
  logic        pulse_in = 1'b0;
  logic        busy, valid, in_window, too_short, too_long;
  logic [15:0] width_ms;

  int n_checks = 0;
  int n_bad    = 0;
  int n_valid  = 0;
  int base;

  pulse_width_detector #(
    .CLK_FREQ   (10000),
    .MIN_MS     (2),
    .MAX_MS     (5),
    .SYNC_STAGES(2)
  ) dut (
    ._clk     (_clk),
    ._reset   (_reset),
    .pulse_in (pulse_in),
    .busy     (busy),
    .valid    (valid),
    .width_ms (width_ms),
    .in_window(in_window),
    .too_short(too_short),
    .too_long (too_long)
  );

  always #5 _clk = ~_clk;

  // Count report strobes; a strobe wider than one cycle counts twice.
  always @(posedge _clk) if (valid) n_valid++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge _clk);
  endtask

  // Drive pulse_in high for n clocks, then let the report settle.
  task automatic pulse(input int n);
    @(posedge _clk);
    pulse_in = 1'b1;
    cycles(n);
    pulse_in = 1'b0;
    cycles(10);
  endtask

  // One pulse, expecting a single report with the given width and flags.
  task automatic measure(input string tag, input int n, input logic [15:0] w,
                         input logic [2:0] flags);
    base = n_valid;
    pulse(n);
    check({tag, "_nvalid"}, 16'(n_valid - base), 16'd1);
    check({tag, "_width"}, width_ms, w);
    check({tag, "_flags"}, {13'd0, in_window, too_short, too_long}, {13'd0, flags});
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    // Reset state.
    cycles(3);
    check("rst_outputs", {10'd0, busy, valid, in_window, too_short, too_long, |width_ms},
          16'd0);
    _reset = 1'b1;
    cycles(6);

    // In-window pulse, with busy observed mid-measurement.
    base = n_valid;
    pulse_in = 1'b1;
    cycles(20);
    check("mid_busy", {15'd0, busy}, 16'd1);
    cycles(15);
    pulse_in = 1'b0;
    cycles(10);
    check("w35_nvalid", 16'(n_valid - base), 16'd1);
    check("w35_width", width_ms, 16'd3);
    check("w35_flags", {13'd0, in_window, too_short, too_long}, 16'b100);
    check("w35_busy", {15'd0, busy}, 16'd0);

    // Short pulses and window boundaries.
    measure("w15", 15, 16'd1, 3'b010);
    measure("w1",  1,  16'd0, 3'b010);
    measure("w20", 20, 16'd2, 3'b100);
    measure("w59", 59, 16'd5, 3'b100);

    // Too long: early report while still high, nothing more on the fall.
    base = n_valid;
    @(posedge _clk);
    pulse_in = 1'b1;
    cycles(70);
    check("w80_early_nvalid", 16'(n_valid - base), 16'd1);
    check("w80_width", width_ms, 16'd6);
    check("w80_flags", {13'd0, in_window, too_short, too_long}, 16'b001);
    check("w80_busy_waitlow", {15'd0, busy}, 16'd0);
    cycles(10);
    pulse_in = 1'b0;
    cycles(10);
    check("w80_no_second", 16'(n_valid - base), 16'd1);

    // Pulse high across reset release is never measured.
    @(posedge _clk);
    _reset = 1'b0;
    pulse_in = 1'b1;
    cycles(3);
    base = n_valid;
    _reset = 1'b1;
    cycles(40);
    pulse_in = 1'b0;
    cycles(10);
    check("arm_nvalid", 16'(n_valid - base), 16'd0);
    check("arm_width", width_ms, 16'd0);
    measure("arm_w35", 35, 16'd3, 3'b100);

    // Reset 20 cycles into a pulse clears outputs at once, no report.
    base = n_valid;
    @(posedge _clk);
    pulse_in = 1'b1;
    cycles(20);
    check("midrst_busy_before", {15'd0, busy}, 16'd1);
    _reset = 1'b0;
    #1;
    check("midrst_outputs", {10'd0, busy, valid, in_window, too_short, too_long, |width_ms},
          16'd0);
    cycles(5);
    pulse_in = 1'b0;
    cycles(2);
    _reset = 1'b1;
    cycles(10);
    check("midrst_nvalid", 16'(n_valid - base), 16'd0);

    // Back-to-back: 35 high, 1 low, 25 high.
    base = n_valid;
    @(posedge _clk);
    pulse_in = 1'b1;
    cycles(35);
    pulse_in = 1'b0;
    cycles(1);
    pulse_in = 1'b1;
    cycles(12);
    check("b2b_first_nvalid", 16'(n_valid - base), 16'd1);
    check("b2b_first_width", width_ms, 16'd3);
    check("b2b_first_flags", {13'd0, in_window, too_short, too_long}, 16'b100);
    cycles(13);
    pulse_in = 1'b0;
    cycles(10);
    check("b2b_second_nvalid", 16'(n_valid - base), 16'd2);
    check("b2b_second_width", width_ms, 16'd2);
    check("b2b_second_flags", {13'd0, in_window, too_short, too_long}, 16'b100);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
